fetch_ctrl: RTL and testbench

Consumer end of the fetch interface for the 12-bit processor. It dequeues instructions from `fetch` when they are ready and downstream has room, and drives `restart_i`/`restart_addr_i` into `fetch` after reset, on absolute jumps and on taken relative branches. All other instructions go into a one-entry issue register with a valid/stall handshake toward the execute stage. It also detects HALT and stops dequeuing.

---
 rtl/fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch consumer: dequeues instructions, redirects fetch on reset/jumps/taken branches, and feeds a one-entry issue register.
// Optional macro FETCH_CTRL_REL_BRANCH_EN enables decoding opcode 4'hE as a conditional PC-relative branch.
module fetch_ctrl #(
    parameter int                 I_WIDTH    = 12,
    parameter int                 A_WIDTH    = 8,
    parameter logic [A_WIDTH-1:0] RESET_ADDR = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [I_WIDTH-1:0] instruction_data_i,
    input  logic [A_WIDTH-1:0] instruction_addr_i,
    input  logic               instruction_ready_i,
    output logic               deque_o,
    output logic               restart_o,
    output logic [A_WIDTH-1:0] restart_addr_o,
    input  logic               cond_i,
    output logic               issue_valid_o,
    output logic [I_WIDTH-1:0] issue_data_o,
    output logic [A_WIDTH-1:0] issue_addr_o,
    input  logic               issue_stall_i,
    output logic               halted_o
);

    typedef enum logic [1:0] {
        S_RESTART = 2'd0,
        S_RUN     = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [3:0] OP_JMP = 4'hF;
    localparam logic [3:0] OP_BR  = 4'hE;

    state_t             state_q;
    logic               restart_q;
    logic [A_WIDTH-1:0] restart_addr_q;
    logic               halted_q;

    logic               issue_valid_q, issue_valid_d;
    logic [I_WIDTH-1:0] issue_data_q, issue_data_d;
    logic [A_WIDTH-1:0] issue_addr_q, issue_addr_d;

    logic [3:0]         opcode;
    logic [A_WIDTH-1:0] imm;
    logic               is_halt;
    logic               is_jmp;
    logic               is_br;
    logic               br_taken;
    logic               deque;
    logic               issue_load;
    logic               redirect;
    logic               halt_pop;
    logic [A_WIDTH-1:0] redirect_target;

    assign opcode  = instruction_data_i[I_WIDTH-1 -: 4];
    assign imm     = instruction_data_i[A_WIDTH-1:0];
    assign is_halt = (instruction_data_i == '0);
    assign is_jmp  = (opcode == OP_JMP);

`ifdef FETCH_CTRL_REL_BRANCH_EN
    assign is_br    = (opcode == OP_BR);
    assign br_taken = is_br && cond_i;
`else
    logic unused_cond;
    assign unused_cond = cond_i ^ (opcode == OP_BR);
    assign is_br       = 1'b0;
    assign br_taken    = 1'b0;
`endif

    // A branch target is relative to the branch's own address and wraps modulo the address space.
    assign redirect_target = br_taken ? (instruction_addr_i + imm) : imm;

    always_comb begin
        deque = (state_q == S_RUN) && instruction_ready_i
                && (!issue_valid_q || !issue_stall_i);
    end

    assign issue_load = deque && !is_halt && !is_jmp && !is_br;
    assign redirect   = deque && (is_jmp || br_taken);
    assign halt_pop   = deque && is_halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_RESTART;
            restart_q      <= 1'b1;
            restart_addr_q <= RESET_ADDR;
            halted_q       <= 1'b0;
        end else begin
            case (state_q)
                S_RESTART: begin
                    state_q   <= S_RUN;
                    restart_q <= 1'b0;
                end
                S_RUN: begin
                    if (halt_pop) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (redirect) begin
                        state_q        <= S_RESTART;
                        restart_q      <= 1'b1;
                        restart_addr_q <= redirect_target;
                    end
                end
                S_HALT: begin
                    state_q   <= S_HALT;
                    restart_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_RESTART;
                    restart_q <= 1'b1;
                end
            endcase
        end
    end

    // Redirects never flush the issue register: its contents precede the jump in program order.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        issue_addr_d  = issue_addr_q;
        if (issue_load) begin
            issue_valid_d = 1'b1;
            issue_data_d  = instruction_data_i;
            issue_addr_d  = instruction_addr_i;
        end else if (issue_valid_q && !issue_stall_i) begin
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
            issue_addr_q  <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
            issue_addr_q  <= issue_addr_d;
        end
    end

    assign deque_o        = deque;
    assign restart_o      = restart_q;
    assign restart_addr_o = restart_addr_q;
    assign issue_valid_o  = issue_valid_q;
    assign issue_data_o   = issue_data_q;
    assign issue_addr_o   = issue_addr_q;
    assign halted_o       = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed vectors push expected issues/restarts, a monitor pops and compares.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] instruction_data_i;
    logic [7:0]  instruction_addr_i;
    logic        instruction_ready_i;
    logic        deque_o;
    logic        restart_o;
    logic [7:0]  restart_addr_o;
    logic        cond_i;
    logic        issue_valid_o;
    logic [11:0] issue_data_o;
    logic [7:0]  issue_addr_o;
    logic        issue_stall_i;
    logic        halted_o;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .I_WIDTH    (12),
        .A_WIDTH    (8),
        .RESET_ADDR (8'h00)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction_data_i  (instruction_data_i),
        .instruction_addr_i  (instruction_addr_i),
        .instruction_ready_i (instruction_ready_i),
        .deque_o             (deque_o),
        .restart_o           (restart_o),
        .restart_addr_o      (restart_addr_o),
        .cond_i              (cond_i),
        .issue_valid_o       (issue_valid_o),
        .issue_data_o        (issue_data_o),
        .issue_addr_o        (issue_addr_o),
        .issue_stall_i       (issue_stall_i),
        .halted_o            (halted_o)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [19:0] issue_q[$];
    logic [7:0]  rst_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    // Monitor: every accepted issue and every restart cycle must match the head of its queue.
    initial begin
        logic [19:0] exp_iss;
        logic [7:0]  exp_rs;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (issue_valid_o && !issue_stall_i) begin
                    if (issue_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_issue: got %03h@%02h, required none", issue_data_o, issue_addr_o);
                    end else begin
                        exp_iss = issue_q.pop_front();
                        check("issue", {12'h0, issue_data_o, issue_addr_o}, {12'h0, exp_iss});
                        $display("issue %03h@%02h (expected %03h@%02h)", issue_data_o, issue_addr_o, exp_iss[19:8], exp_iss[7:0]);
                    end
                end
                if (restart_o) begin
                    check("no_deque_in_restart", {31'h0, deque_o}, 32'h0);
                    if (rst_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_restart: got addr %02h, required none", restart_addr_o);
                    end else begin
                        exp_rs = rst_q.pop_front();
                        check("restart_addr", {24'h0, restart_addr_o}, {24'h0, exp_rs});
                        $display("restart to %02h (expected %02h)", restart_addr_o, exp_rs);
                    end
                end
            end
        end
    end

    // One cycle of stimulus; expected deque and resulting issue/restart are supplied by hand.
    task automatic cyc(input logic [11:0] d, input logic [7:0] a, input logic rdy, input logic stl,
                       input logic cnd, input logic exp_dq, input logic exp_iss, input logic exp_rs,
                       input logic [7:0] tgt, input string nm);
        @(posedge clk);
        #1;
        instruction_data_i  = d;
        instruction_addr_i  = a;
        instruction_ready_i = rdy;
        issue_stall_i       = stl;
        cond_i              = cnd;
        if (exp_iss) issue_q.push_back({d, a});
        if (exp_rs)  rst_q.push_back(tgt);
        #2;
        check({nm, "_deque"}, {31'h0, deque_o}, {31'h0, exp_dq});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset               = 1'b1;
        instruction_ready_i = 1'b0;
        issue_stall_i       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_restart",      {31'h0, restart_o},      32'h1);
        check("rst_restart_addr", {24'h0, restart_addr_o}, 32'h0);
        check("rst_issue_valid",  {31'h0, issue_valid_o},  32'h0);
        check("rst_halted",       {31'h0, halted_o},       32'h0);
        reset               = 1'b0;
        instruction_data_i  = 12'h123;
        instruction_addr_i  = 8'h00;
        instruction_ready_i = 1'b1;
        rst_q.push_back(8'h00);
        #2;
        check("restart_cycle_deque", {31'h0, deque_o}, 32'h0);
    endtask

    initial begin
        reset               = 1'b1;
        instruction_data_i  = '0;
        instruction_addr_i  = '0;
        instruction_ready_i = 1'b0;
        issue_stall_i       = 1'b0;
        cond_i              = 1'b0;
        do_reset();

        // Streaming, then stall holding 456
        cyc(12'h123, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, "stream0");
        cyc(12'h456, 8'h01, 1, 0, 0, 1, 1, 0, 8'h00, "stream1");
        cyc(12'h789, 8'h02, 1, 1, 0, 0, 0, 0, 8'h00, "stall0");
        check("stall_hold0", {20'h0, issue_data_o}, 32'h456);
        cyc(12'h789, 8'h02, 1, 1, 0, 0, 0, 0, 8'h00, "stall1");
        cyc(12'h789, 8'h02, 1, 1, 0, 0, 0, 0, 8'h00, "stall2");
        check("stall_hold2", {20'h0, issue_data_o}, 32'h456);
        cyc(12'h789, 8'h02, 1, 0, 0, 1, 1, 0, 8'h00, "unstall");

        // JMP
        cyc(12'hF40, 8'h05, 1, 0, 0, 1, 0, 1, 8'h40, "jmp");
        cyc(12'h111, 8'h40, 1, 0, 0, 0, 0, 0, 8'h00, "jmp_restart");
        cyc(12'h111, 8'h40, 1, 0, 0, 1, 1, 0, 8'h00, "jmp_resume");

`ifdef FETCH_CTRL_REL_BRANCH_EN
        cyc(12'hEFE, 8'h10, 1, 0, 1, 1, 0, 1, 8'h0E, "br_taken");
        cyc(12'hE05, 8'hFE, 1, 0, 1, 0, 0, 0, 8'h00, "br_restart0");
        cyc(12'hE05, 8'hFE, 1, 0, 1, 1, 0, 1, 8'h03, "br_wrap");
        cyc(12'hE22, 8'h20, 1, 0, 0, 0, 0, 0, 8'h00, "br_restart1");
        cyc(12'hE22, 8'h20, 1, 0, 0, 1, 0, 0, 8'h00, "br_not_taken");
        cyc(12'h222, 8'h21, 1, 0, 0, 1, 1, 0, 8'h00, "after_nt");
        check("nt_no_restart", {31'h0, restart_o}, 32'h0);
`else
        cyc(12'hE12, 8'h41, 1, 0, 1, 1, 1, 0, 8'h00, "op_e_plain");
        cyc(12'h222, 8'h42, 1, 0, 1, 1, 1, 0, 8'h00, "after_op_e");
        check("op_e_no_restart", {31'h0, restart_o}, 32'h0);
`endif

        // HALT waiting behind a stalled instruction
        cyc(12'h333, 8'h30, 1, 0, 0, 1, 1, 0, 8'h00, "pre_halt");
        cyc(12'h000, 8'h31, 1, 1, 0, 0, 0, 0, 8'h00, "halt_stall0");
        check("halt_stall_hold", {20'h0, issue_data_o}, 32'h333);
        cyc(12'h000, 8'h31, 1, 1, 0, 0, 0, 0, 8'h00, "halt_stall1");
        cyc(12'h000, 8'h31, 1, 0, 0, 1, 0, 0, 8'h00, "halt_pop");
        cyc(12'h444, 8'h32, 1, 0, 0, 0, 0, 0, 8'h00, "halted0");
        check("halted_set",        {31'h0, halted_o},  32'h1);
        check("halted_no_restart", {31'h0, restart_o}, 32'h0);
        cyc(12'h444, 8'h32, 1, 1, 0, 0, 0, 0, 8'h00, "halted1");
        check("halted_stays", {31'h0, halted_o}, 32'h1);

        // Reset leaves HALT
        do_reset();
        cyc(12'h555, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, "post_reset");
        cyc(12'h000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, "idle");
        @(posedge clk);
        #1;
        check("issue_queue_empty",   issue_q.size(), 32'h0);
        check("restart_queue_empty", rst_q.size(),   32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
